// File: rtl/display_collector.sv
// Receive end of the display stream: rebuilds the PE, 3x3 and 2x2 result matrices from the
// byte-serial tagged stream, cross-checks them at frame end and flags protocol violations.
module display_collector #(
  parameter int DATA_W  = 8,
  parameter int GROUP_N = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [DATA_W-1:0]          disp_data_i,
  input  logic [2:0]                 disp_tag_i,
  output logic [GROUP_N*DATA_W-1:0]  res_pe_o,
  output logic [GROUP_N*DATA_W-1:0]  res_3x3_o,
  output logic [GROUP_N*DATA_W-1:0]  res_2x2_o,
  output logic                       frame_valid_o,
  output logic                       frame_done_o,
  output logic                       match_3x3_o,
  output logic                       match_2x2_o,
  output logic                       proto_err_o
);

  localparam int MAT_W = GROUP_N * DATA_W;
  localparam int CNT_W = $clog2(GROUP_N + 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(GROUP_N);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PE,
    S_3X3,
    S_2X2,
    S_CHECK,
    S_DONE,
    S_ERR
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [MAT_W-1:0]   pe_q, pe_d, m3_q, m3_d, m2_q, m2_d;
  logic               valid_q, valid_d;
  logic               done_q, done_d;
  logic               match3_q, match3_d;
  logic               match2_q, match2_d;
  logic               err_q, err_d;

  logic [2:0]         grp;
  logic               start, fault, wr_en;
  logic [1:0]         wr_grp;
  logic [CNT_W-1:0]   wr_idx;

  function automatic logic [MAT_W-1:0] put_byte(input logic [MAT_W-1:0] m,
                                                input logic [CNT_W-1:0] idx,
                                                input logic [DATA_W-1:0] b);
    logic [MAT_W-1:0] r;
    r = m;
    for (int i = 0; i < GROUP_N; i++) begin
      if (CNT_W'(i) == idx) r[i*DATA_W +: DATA_W] = b;
    end
    return r;
  endfunction

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      pe_q     <= '0;
      m3_q     <= '0;
      m2_q     <= '0;
      valid_q  <= 1'b0;
      done_q   <= 1'b0;
      match3_q <= 1'b0;
      match2_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      pe_q     <= pe_d;
      m3_q     <= m3_d;
      m2_q     <= m2_d;
      valid_q  <= valid_d;
      done_q   <= done_d;
      match3_q <= match3_d;
      match2_q <= match2_d;
      err_q    <= err_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    pe_d     = pe_q;
    m3_d     = m3_q;
    m2_d     = m2_q;
    valid_d  = valid_q;
    done_d   = 1'b0;
    match3_d = match3_q;
    match2_d = match2_q;
    err_d    = err_q;
    start    = 1'b0;
    fault    = 1'b0;
    wr_en    = 1'b0;
    wr_grp   = 2'd0;
    wr_idx   = '0;

    unique case (state_q)
      S_PE:    grp = 3'd1;
      S_3X3:   grp = 3'd2;
      S_2X2:   grp = 3'd3;
      default: grp = 3'd0;
    endcase

    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (disp_tag_i == 3'd1) start = 1'b1;
        else if (disp_tag_i != 3'd0 && disp_tag_i != 3'd4) fault = 1'b1;
      end
      S_PE, S_3X3, S_2X2: begin
        if (disp_tag_i == grp && cnt_q != CNT_FULL) begin
          wr_en  = 1'b1;
          wr_grp = grp[1:0];
          wr_idx = cnt_q;
          cnt_d  = cnt_q + CNT_W'(1);
        end else if (disp_tag_i == grp + 3'd1 && cnt_q == CNT_FULL) begin
          // Tag of the following group (tag 4 after 2x2) closes the current group.
          if (grp == 3'd3) begin
            state_d = S_CHECK;
          end else begin
            wr_en   = 1'b1;
            wr_grp  = disp_tag_i[1:0];
            wr_idx  = '0;
            cnt_d   = CNT_W'(1);
            state_d = (grp == 3'd1) ? S_3X3 : S_2X2;
          end
        end else begin
          fault = 1'b1;
        end
      end
      S_CHECK: begin
        if (disp_tag_i == 3'd4) begin
          match3_d = (pe_q == m3_q);
          match2_d = (pe_q == m2_q);
          valid_d  = 1'b1;
          done_d   = 1'b1;
          cnt_d    = '0;
          state_d  = S_DONE;
        end else begin
          fault = 1'b1;
        end
      end
      S_ERR: begin
        if (disp_tag_i == 3'd0) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else if (disp_tag_i == 3'd1) begin
          start = 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase

    if (start) begin
      valid_d  = 1'b0;
      err_d    = 1'b0;
      match3_d = 1'b0;
      match2_d = 1'b0;
      wr_en    = 1'b1;
      wr_grp   = 2'd1;
      wr_idx   = '0;
      cnt_d    = CNT_W'(1);
      state_d  = S_PE;
    end

    if (fault) begin
      err_d   = 1'b1;
      state_d = S_ERR;
    end

    if (wr_en) begin
      unique case (wr_grp)
        2'd1:    pe_d = put_byte(pe_q, wr_idx, disp_data_i);
        2'd2:    m3_d = put_byte(m3_q, wr_idx, disp_data_i);
        2'd3:    m2_d = put_byte(m2_q, wr_idx, disp_data_i);
        default: ;
      endcase
    end
  end

  assign res_pe_o      = pe_q;
  assign res_3x3_o     = m3_q;
  assign res_2x2_o     = m2_q;
  assign frame_valid_o = valid_q;
  assign frame_done_o  = done_q;
  assign match_3x3_o   = match3_q;
  assign match_2x2_o   = match2_q;
  assign proto_err_o   = err_q;

endmodule

// File: tb/tb_display_collector.sv
// Bench for display_collector: vector table, directed corner sequences and a randomized
// tagged stream, all checked against a frame-position model of the receive protocol.
module tb_display_collector;

  logic        clk;
  logic        reset;
  logic [7:0]  disp_data_i;
  logic [2:0]  disp_tag_i;
  logic [31:0] res_pe_o, res_3x3_o, res_2x2_o;
  logic        frame_valid_o, frame_done_o, match_3x3_o, match_2x2_o, proto_err_o;

  display_collector #(.DATA_W(8), .GROUP_N(4)) dut (
    .clk           (clk),
    .reset         (reset),
    .disp_data_i   (disp_data_i),
    .disp_tag_i    (disp_tag_i),
    .res_pe_o      (res_pe_o),
    .res_3x3_o     (res_3x3_o),
    .res_2x2_o     (res_2x2_o),
    .frame_valid_o (frame_valid_o),
    .frame_done_o  (frame_done_o),
    .match_3x3_o   (match_3x3_o),
    .match_2x2_o   (match_2x2_o),
    .proto_err_o   (proto_err_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;
  int done_seen = 0;

  // Model: mode 0 idle/done, 1 receiving, 2 first tag 4 seen, 3 error; pos = bytes received.
  int         md_mode, md_pos;
  logic [7:0] md_mem [3][4];
  logic       md_valid, md_done, md_m3, md_m2, md_err;

  function automatic logic [31:0] md_mat(input int g);
    return {md_mem[g][3], md_mem[g][2], md_mem[g][1], md_mem[g][0]};
  endfunction

  task automatic model_reset();
    md_mode = 0; md_pos = 0;
    for (int g = 0; g < 3; g++) for (int k = 0; k < 4; k++) md_mem[g][k] = 8'h00;
    md_valid = 0; md_done = 0; md_m3 = 0; md_m2 = 0; md_err = 0;
  endtask

  task automatic model_start(input logic [7:0] d);
    md_valid = 0; md_err = 0; md_m3 = 0; md_m2 = 0;
    md_mem[0][0] = d; md_pos = 1; md_mode = 1;
  endtask

  task automatic model_step(input logic [2:0] t, input logic [7:0] d);
    int legal;
    md_done = 0;
    case (md_mode)
      0: begin
        if (t == 3'd1) model_start(d);
        else if (t != 3'd0 && t != 3'd4) begin md_err = 1; md_mode = 3; end
      end
      1: begin
        // The only legal tag is the group of the next byte; after 12 bytes that is tag 4.
        legal = md_pos / 4 + 1;
        if (int'(t) != legal) begin md_err = 1; md_mode = 3; end
        else if (t == 3'd4) md_mode = 2;
        else begin md_mem[md_pos/4][md_pos%4] = d; md_pos++; end
      end
      2: begin
        if (t == 3'd4) begin
          md_m3 = (md_mat(0) == md_mat(1));
          md_m2 = (md_mat(0) == md_mat(2));
          md_valid = 1; md_done = 1; md_mode = 0;
        end else begin md_err = 1; md_mode = 3; end
      end
      default: begin
        if (t == 3'd0) md_mode = 0;
        else if (t == 3'd1) model_start(d);
      end
    endcase
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic check_all();
    chk("res_pe", res_pe_o, md_mat(0));
    chk("res_3x3", res_3x3_o, md_mat(1));
    chk("res_2x2", res_2x2_o, md_mat(2));
    chk("frame_valid", 32'(frame_valid_o), 32'(md_valid));
    chk("frame_done", 32'(frame_done_o), 32'(md_done));
    chk("match_3x3", 32'(match_3x3_o), 32'(md_m3));
    chk("match_2x2", 32'(match_2x2_o), 32'(md_m2));
    chk("proto_err", 32'(proto_err_o), 32'(md_err));
  endtask

  task automatic cyc(input logic [2:0] t, input logic [7:0] d);
    @(negedge clk);
    disp_tag_i  = t;
    disp_data_i = d;
    @(posedge clk);
    model_step(t, d);
    #1;
    if (frame_done_o) done_seen++;
    check_all();
  endtask

  task automatic send_frame(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c);
    for (int k = 0; k < 4; k++) cyc(3'd1, a[8*k +: 8]);
    for (int k = 0; k < 4; k++) cyc(3'd2, b[8*k +: 8]);
    for (int k = 0; k < 4; k++) cyc(3'd3, c[8*k +: 8]);
    cyc(3'd4, 8'hEE);
    cyc(3'd4, 8'hEE);
  endtask

  typedef struct {
    logic [2:0] tag;
    logic [7:0] data;
    logic       done;
    logic       valid;
    logic       err;
    logic       m3;
    logic       m2;
  } vec_t;

  vec_t vt [25];

  task automatic run_vec(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      cyc(vt[i].tag, vt[i].data);
      chk($sformatf("vec%0d_done", i),  32'(frame_done_o),  32'(vt[i].done));
      chk($sformatf("vec%0d_valid", i), 32'(frame_valid_o), 32'(vt[i].valid));
      chk($sformatf("vec%0d_err", i),   32'(proto_err_o),   32'(vt[i].err));
      chk($sformatf("vec%0d_m3", i),    32'(match_3x3_o),   32'(vt[i].m3));
      chk($sformatf("vec%0d_m2", i),    32'(match_2x2_o),   32'(vt[i].m2));
    end
  endtask

  initial begin
    logic [7:0] bytes4 [4];
    int d0;
    bytes4 = '{8'd11, 8'd12, 8'd21, 8'd22};
    // Legal frame: 12 bytes, two tag-4 cycles, then idle.
    for (int g = 0; g < 3; g++)
      for (int k = 0; k < 4; k++) vt[g*4+k] = '{3'(g+1), bytes4[k], 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vt[12] = '{3'd4, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vt[13] = '{3'd4, 8'h00, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    vt[14] = '{3'd0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    // Tag 0 after two 3x3 bytes: error, no completion.
    for (int k = 0; k < 4; k++) vt[15+k] = '{3'd1, 8'(k+1), 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vt[19] = '{3'd2, 8'h05, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vt[20] = '{3'd2, 8'h06, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vt[21] = '{3'd0, 8'h07, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    vt[22] = '{3'd4, 8'h08, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    vt[23] = '{3'd4, 8'h09, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    vt[24] = '{3'd0, 8'h0A, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};

    reset = 1'b0;
    disp_tag_i = 3'd0;
    disp_data_i = 8'h00;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all();
    chk("reset_res_pe", res_pe_o, 32'h0);
    @(negedge clk);
    reset = 1'b1;

    run_vec(0, 14);
    chk("t1_res_pe", res_pe_o, 32'h16150C0B);
    chk("t1_res_3x3", res_3x3_o, 32'h16150C0B);
    chk("t1_res_2x2", res_2x2_o, 32'h16150C0B);
    run_vec(15, 24);

    // 2x2 path differs in c22.
    send_frame(32'h16150C0B, 32'h16150C0B, 32'h17150C0B);
    chk("t2_match_3x3", 32'(match_3x3_o), 32'd1);
    chk("t2_match_2x2", 32'(match_2x2_o), 32'd0);
    chk("t2_valid", 32'(frame_valid_o), 32'd1);

    // Early advance to 3x3, recovery through tag 0 and a legal frame.
    for (int k = 0; k < 3; k++) cyc(3'd1, 8'h30 + 8'(k));
    cyc(3'd2, 8'h40);
    chk("t3_err_set", 32'(proto_err_o), 32'd1);
    cyc(3'd0, 8'h00);
    cyc(3'd1, 8'hA1);
    chk("t3_err_clear", 32'(proto_err_o), 32'd0);
    for (int k = 1; k < 4; k++) cyc(3'd1, 8'hA1 + 8'(k));
    for (int k = 0; k < 4; k++) cyc(3'd2, 8'hA1 + 8'(k));
    for (int k = 0; k < 4; k++) cyc(3'd3, 8'hA1 + 8'(k));
    cyc(3'd4, 8'h00);
    cyc(3'd4, 8'h00);
    chk("t3_m3", 32'(match_3x3_o), 32'd1);
    chk("t3_m2", 32'(match_2x2_o), 32'd1);
    chk("t3_res_pe", res_pe_o, 32'hA4A3A2A1);

    // Back-to-back frames.
    d0 = done_seen;
    send_frame(32'h01020304, 32'h01020304, 32'h01020304);
    send_frame(32'h55667788, 32'h55667788, 32'h55660088);
    cyc(3'd0, 8'h00);
    chk("t5_done_count", 32'(done_seen - d0), 32'd2);
    chk("t5_res_pe", res_pe_o, 32'h55667788);
    chk("t5_m2", 32'(match_2x2_o), 32'd0);

    // Asynchronous reset in the middle of the 3x3 group.
    for (int k = 0; k < 4; k++) cyc(3'd1, 8'hC0 + 8'(k));
    cyc(3'd2, 8'hD0);
    cyc(3'd2, 8'hD1);
    @(negedge clk);
    #2;
    reset = 1'b0;
    #1;
    model_reset();
    chk("t6_res_pe", res_pe_o, 32'h0);
    chk("t6_res_3x3", res_3x3_o, 32'h0);
    chk("t6_flags", {27'd0, frame_valid_o, frame_done_o, match_3x3_o, match_2x2_o, proto_err_o}, 32'h0);
    @(negedge clk);
    reset = 1'b1;
    disp_tag_i = 3'd0;
    send_frame(32'h9ABCDEF0, 32'h9ABCDEF0, 32'h9ABCDEF0);
    chk("t6_after_res", res_2x2_o, 32'h9ABCDEF0);
    chk("t6_after_m", {30'd0, match_3x3_o, match_2x2_o}, 32'h3);

    // Randomized mostly-legal stream with occasional corrupted tags.
    for (int f = 0; f < 40; f++) begin
      for (int s = 0; s < 14; s++) begin
        logic [2:0] t;
        t = (s < 12) ? 3'(s / 4 + 1) : 3'd4;
        if ($urandom_range(0, 19) == 0) t = 3'($urandom_range(0, 7));
        cyc(t, 8'($urandom_range(0, 3)));
      end
      if ($urandom_range(0, 3) == 0) cyc(3'd0, 8'($urandom));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
